imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined LEGv8 immediate generator for the decode stage.
//  - Takes 32-bit instructions through a valid/ready handshake.
//  - Classifies each by opcode; extracts the immediate and sign- or zero-extends it to N bits.
//  - Adds B-type and I-type formats, an optional MOVZ format, an illegal-opcode flag and a

---
 rtl/imm_gen_pipe.sv | 177 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined LEGv8 immediate generator for the decode stage.
//   Stage 1 captures the instruction word, and stage 2 captures the decoded
//   immediate, format code and illegal flag. Both stages are elastic, so the
//   block sustains one result per cycle and can absorb output backpressure.
//
// Parameters
//   N      output immediate width (32..64). The extension is done at 64 bits
//          and the low N bits are presented.
//   CNT_W  width of the saturating illegal-result counter.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     instr is valid
//   in_ready     stage 1 can accept this cycle (combinational, no bubble)
//   instr        32-bit instruction word
//   out_valid    imm/fmt/illegal are valid
//   out_ready    downstream accepts the result
//   imm          extended immediate (N bits)
//   fmt          0 none, 1 D, 2 CB, 3 B, 4 I, 5 MOVZ
//   illegal      opcode matched no supported format
//   cnt_clr      synchronous clear of illegal_cnt (wins over an increment)
//   illegal_cnt  saturating count of illegal results delivered downstream
//
// Build option
//   IMMGEN_MOVZ_EN  when defined, MOVZ decodes as fmt 5 with a shifted
//                   16-bit immediate. When undefined, MOVZ opcodes are
//                   reported as illegal.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int N     = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] instr_q, instr_d;

  // Stage 2 state
  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] imm_q, imm_d;
  logic [2:0]   fmt_q, fmt_d;
  logic         illegal_q, illegal_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decode results for the word held in stage 1
  logic [63:0] dec_imm64;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;

  logic s2_ready;

  assign s2_ready = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  assign out_valid   = s2_valid_q;
  assign imm         = imm_q;
  assign fmt         = fmt_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

  // Opcode classification. The order of the items matters because the first
  // match wins. Branch offsets are left unscaled because the branch adder
  // applies the word shift.
  always_comb begin
    dec_imm64   = 64'd0;
    dec_fmt     = 3'd0;
    dec_illegal = 1'b0;
    casez (instr_q[31:21])
      11'b11111000010,
      11'b11111000000: begin // LDUR / STUR
        dec_fmt   = 3'd1;
        dec_imm64 = {{55{instr_q[20]}}, instr_q[20:12]};
      end
      11'b10110100???: begin // CBZ
        dec_fmt   = 3'd2;
        dec_imm64 = {{45{instr_q[23]}}, instr_q[23:5]};
      end
      11'b000101?????: begin // B
        dec_fmt   = 3'd3;
        dec_imm64 = {{38{instr_q[25]}}, instr_q[25:0]};
      end
      11'b1001000100?,
      11'b1101000100?: begin // ADDI / SUBI
        dec_fmt   = 3'd4;
        dec_imm64 = {52'd0, instr_q[21:10]};
      end
      11'b110100101??: begin // MOVZ
`ifdef IMMGEN_MOVZ_EN
        // The hw field selects a 16-bit lane. Lanes that fall beyond N are
        // lost when the result is truncated to N bits.
        dec_fmt   = 3'd5;
        dec_imm64 = {48'd0, instr_q[20:5]} << {instr_q[22:21], 4'b0000};
`else
        dec_illegal = 1'b1;
`endif
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Next-state logic for both pipeline stages and the counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    instr_d    = instr_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        instr_d = instr;
      end
    end

    // Stage 2 is written only when it is free or draining, so a stalled
    // result stays stable on the outputs.
    s2_valid_d = s2_valid_q;
    imm_d      = imm_q;
    fmt_d      = fmt_q;
    illegal_d  = illegal_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        imm_d     = dec_imm64[N-1:0];
        fmt_d     = dec_fmt;
        illegal_d = dec_illegal;
      end
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s2_valid_q && out_ready && illegal_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      instr_q    <= 32'd0;
      s2_valid_q <= 1'b0;
      imm_q      <= '0;
      fmt_q      <= 3'd0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      instr_q    <= instr_d;
      s2_valid_q <= s2_valid_d;
      imm_q      <= imm_d;
      fmt_q      <= fmt_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
module tb_imm_gen_pipe;

  localparam int N     = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     imm;
  logic [2:0]       fmt;
  logic             illegal;
  logic             cnt_clr;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .imm         (imm),
    .fmt         (fmt),
    .illegal     (illegal),
    .cnt_clr     (cnt_clr),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_out  = 0;

`ifdef IMMGEN_MOVZ_EN
  localparam logic [63:0] MOVZ1_IMM = 64'h0000_0000_ABCD_0000;
  localparam logic [2:0]  MOVZ_FMT  = 3'd5;
  localparam logic        MOVZ_ILL  = 1'b0;
  localparam logic [63:0] MOVZ3_IMM = 64'h0001_0000_0000_0000;
  localparam int          MOVZ_CNT  = 0;
`else
  localparam logic [63:0] MOVZ1_IMM = 64'h0;
  localparam logic [2:0]  MOVZ_FMT  = 3'd0;
  localparam logic        MOVZ_ILL  = 1'b1;
  localparam logic [63:0] MOVZ3_IMM = 64'h0;
  localparam int          MOVZ_CNT  = 2;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every delivered result and verifies that
  // a stalled result does not change before it is taken.
  logic held_v = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_imm", imm, held.imm);
        chk("stall_fmt", {61'd0, fmt}, {61'd0, held.fmt});
        chk("stall_ill", {63'd0, illegal}, {63'd0, held.ill});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got imm=%h fmt=%0d ill=%0b expected no output", imm, fmt, illegal);
        end else begin
          e = q.pop_front();
          n_out++;
          $display("out #%0d imm=%h fmt=%0d illegal=%0b", n_out, imm, fmt, illegal);
          chk("out_imm", imm, e.imm);
          chk("out_fmt", {61'd0, fmt}, {61'd0, e.fmt});
          chk("out_ill", {63'd0, illegal}, {63'd0, e.ill});
        end
      end
      held_v   = out_valid && !out_ready;
      held.imm = imm;
      held.fmt = fmt;
      held.ill = illegal;
    end
  end

  task automatic send(input logic [31:0] w, input logic [63:0] ei, input logic [2:0] ef, input logic el);
    int   n;
    logic rdy;
    exp_t e;
    in_valid = 1'b1;
    instr    = w;
    n        = 0;
    rdy      = 1'b0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      n++;
      if (rdy) begin
        e.imm = ei; e.fmt = ef; e.ill = el;
        q.push_back(e);
        n_push++;
        $display("in  %h exp imm=%h fmt=%0d illegal=%0b", w, ei, ef, el);
      end
      @(posedge clk);
    end while (!rdy && n < 50);
    #1;
    in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept of %h", w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_exp[5];
    int n;
    cnt_exp = '{1, 2, 3, 3, 3};
    reset = 1'b1; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cnt", {62'd0, illegal_cnt}, 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_fmt", {61'd0, fmt}, 64'd0);
    chk("rst_ill", {63'd0, illegal}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Deliver one illegal word so the counter is non-zero before the reset test
    send(32'h0000_0000, 64'd0, 3'd0, 1'b1);
    drain();
    chk("cnt_pre_reset", {62'd0, illegal_cnt}, 64'd1);

    // Reset mid-stream with out_ready high
    in_valid = 1'b1; instr = 32'hF85F8041;
    @(posedge clk); #1;
    instr = 32'h0000_0000;
    @(posedge clk); #1;
    chk("midrst_pre_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_cnt", {62'd0, illegal_cnt}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("postrst_cnt", {62'd0, illegal_cnt}, 64'd0);
    chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (4) @(posedge clk);
    #1;

    // Latency: a lone LDUR appears on the second edge after acceptance
    send(32'hF85F8041, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0);
    @(negedge clk);
    chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // Format coverage, back to back
    send(32'hB4FFFFE3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b0);
    send(32'h1400_0004, 64'd4, 3'd3, 1'b0);
    send(32'h913FFC00, 64'h0000_0000_0000_0FFF, 3'd4, 1'b0);
    send(32'hD2B579A0, MOVZ1_IMM, MOVZ_FMT, MOVZ_ILL);
    send(32'hD2E00020, MOVZ3_IMM, MOVZ_FMT, MOVZ_ILL);
    drain();
    chk("cnt_after_movz", {62'd0, illegal_cnt}, 64'(MOVZ_CNT));

    // Burst of four with a three-cycle downstream stall
    fork
      begin
        send(32'hF810_0000, 64'hFFFF_FFFF_FFFF_FF00, 3'd1, 1'b0);
        send(32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0);
        send(32'hD100_0400, 64'd1, 3'd4, 1'b0);
        send(32'hB400_0020, 64'd1, 3'd2, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturating counter with CNT_W=2
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_cleared", {62'd0, illegal_cnt}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      send(32'h0000_0000, 64'd0, 3'd0, 1'b1);
      drain();
      chk("cnt_sat", {62'd0, illegal_cnt}, 64'(cnt_exp[i]));
    end

    // Sixth illegal delivered in the same cycle as cnt_clr
    out_ready = 1'b0;
    send(32'h0000_0000, 64'd0, 3'd0, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cnt6_ready_to_deliver", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", {62'd0, illegal_cnt}, 64'd0);
    drain();
    chk("cnt_final", {62'd0, illegal_cnt}, 64'd0);

    chk("sb_empty", 64'(q.size()), 64'd0);
    chk("out_count", 64'(n_out), 64'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
